alu_serial: RTL and testbench

- Digit-serial N-bit ALU; successor to the single-bit ALU slice.
- Processes DIGIT bits per clock from the LSB upward, holding the ripple carry in a register between digits.
- Accepts operations over a valid/ready handshake and returns result plus flags over a second valid/ready handshake.
- Used by the sequencer where area matters more than single-cycle latency.

---
 rtl/alu_serial.sv | 135 +++++++++++++
 tb/tb_alu_serial.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial.sv
// alu_serial: digit-serial ALU that works through DIGIT bits per clock from the LSB, with valid/ready on both sides.
// Optional ALU_SERIAL_B2B_EN: accept the next operation on the same edge that a result is taken.
module alu_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);
    localparam int N = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("alu_serial: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, c_out_q, zero_q, neg_q, ovf_q;
    logic             accept, last, arith, dig_ovf;
    logic [IW-1:0]    base;
    logic [DIGIT-1:0] a_dig, b_dig, bx_dig, slice;
    logic [DIGIT:0]   sum;

`ifdef ALU_SERIAL_B2B_EN
    assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
`else
    assign in_ready = (state_q == IDLE);
`endif
    assign accept    = in_valid && in_ready;
    assign last      = (cnt_q == LAST);
    assign base      = IW'(int'(cnt_q) * DIGIT);
    assign a_dig     = a_q[base +: DIGIT];
    assign b_dig     = b_q[base +: DIGIT];
    assign arith     = (op_q[2:1] == 2'b00);
    assign bx_dig    = op_q[0] ? ~b_dig : b_dig;
    assign sum       = {1'b0, a_dig} + {1'b0, bx_dig} + {{DIGIT{1'b0}}, carry_q};
    // carry into the MSB is recovered from the MSB's own sum bit
    assign dig_ovf   = a_dig[DIGIT-1] ^ bx_dig[DIGIT-1] ^ sum[DIGIT-1] ^ sum[DIGIT];

    assign out_valid = out_valid_q;
    assign result    = res_q;
    assign c_out     = c_out_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;

    always_comb begin
        case (op_q)
            3'b000, 3'b001: slice = sum[DIGIT-1:0];
            3'b010:         slice = a_dig & b_dig;
            3'b011:         slice = a_dig | b_dig;
            3'b100:         slice = a_dig ^ b_dig;
            3'b101:         slice = ~(a_dig | b_dig);
            3'b110:         slice = a_dig;
            default:        slice = ~b_dig;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        res_d   = res_q;
        if (accept) begin
            cnt_d   = '0;
            carry_d = c_in;
        end
        case (state_q)
            IDLE: state_d = accept ? RUN : IDLE;
            RUN: begin
                res_d[base +: DIGIT] = slice;
                carry_d = sum[DIGIT];
                cnt_d   = last ? '0 : cnt_q + 1'b1;
                state_d = last ? DONE : RUN;
            end
            DONE: state_d = out_ready ? (accept ? RUN : IDLE) : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            c_out_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            out_valid_q <= (state_d == DONE);
            if (accept) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
            end
            if (state_q == RUN && last) begin
                c_out_q <= arith & sum[DIGIT];
                ovf_q   <= arith & dig_ovf;
                zero_q  <= (res_d == '0);
                neg_q   <= res_d[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: directed vector table plus handshake, reset and N=1 sequences for alu_serial.
module tb_alu_serial;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  op;
    logic [15:0] a, b, result;
    logic        c_in, c_out, zero, neg, ovf;
    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [15:0] result1;
    logic        c_out1, zero1, neg1, ovf1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a, b;
        logic        cin;
        logic [15:0] res;
        logic        c, z, n, v;
    } vec_t;

    vec_t vt[14];

    alu_serial #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .c_in(c_in), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .c_out(c_out), .zero(zero),
        .neg(neg), .ovf(ovf)
    );

    alu_serial #(.WIDTH(16), .DIGIT(16)) dut_n1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .op(op), .a(a), .b(b), .c_in(c_in), .out_valid(out_valid1),
        .out_ready(out_ready1), .result(result1), .c_out(c_out1), .zero(zero1),
        .neg(neg1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_flags(input string nm, input logic [15:0] r, input logic c, input logic z,
                             input logic n, input logic v);
        chk({nm, "_result"}, result, r);
        chk({nm, "_c_out"}, c_out, c);
        chk({nm, "_zero"}, zero, z);
        chk({nm, "_neg"}, neg, n);
        chk({nm, "_ovf"}, ovf, v);
    endtask

    task automatic do_op(input vec_t v, input string nm);
        int w;
        op = v.op; a = v.a; b = v.b; c_in = v.cin; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom); a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
        chk({nm, "_in_ready_busy"}, in_ready, 0);
        w = 0;
        while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
        chk({nm, "_latency"}, w, 4);
        chk_flags(nm, v.res, v.c, v.z, v.n, v.v);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        int w, seen;
        int t[3];
        vt[0]  = '{3'b000, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[1]  = '{3'b000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{3'b001, 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{3'b001, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{3'b100, 16'hA5A5, 16'hFFFF, 1'b0, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{3'b010, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{3'b011, 16'h0F00, 16'h8001, 1'b0, 16'h8F01, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[7]  = '{3'b101, 16'h0F0F, 16'h00F0, 1'b0, 16'hF000, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[8]  = '{3'b110, 16'h1234, 16'hFFFF, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{3'b111, 16'h5555, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[10] = '{3'b000, 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[11] = '{3'b001, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[12] = '{3'b001, 16'h0005, 16'h0005, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[13] = '{3'b000, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
        op = '0; a = '0; b = '0; c_in = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk_flags("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ignores_in_valid", in_ready, 1);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // N=1 build: result one edge after accept
        op = 3'b000; a = 16'h0001; b = 16'h0001; c_in = 1'b0; in_valid1 = 1'b1;
        chk("n1_in_ready", in_ready1, 1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        chk("n1_valid_at_accept", out_valid1, 0);
        @(posedge clk); #1;
        chk("n1_valid_after_1", out_valid1, 1);
        chk("n1_result", result1, 16'h0002);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        chk("n1_valid_drop", out_valid1, 0);

        for (int i = 0; i < 14; i++) do_op(vt[i], $sformatf("v%0d", i));

        // backpressure: result stays put while a second op waits
        op = 3'b000; a = 16'h1111; b = 16'h2222; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 3'b100; a = 16'hFFFF; b = 16'h0F0F; c_in = 1'b1;
        w = 0;
        while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
        chk("bp_first_latency", w, 4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_in_ready", in_ready, 0);
            chk_flags("bp_hold", 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_valid_drop", out_valid, 0);
`ifdef ALU_SERIAL_B2B_EN
        chk("bp_after_handshake_in_ready", in_ready, 0);
`else
        chk("bp_after_handshake_in_ready", in_ready, 1);
`endif
        w = 0;
        while (!out_valid && w < 20) begin
            if (!in_ready) in_valid = 1'b0;
            @(posedge clk); #1;
            w++;
        end
        in_valid = 1'b0;
`ifdef ALU_SERIAL_B2B_EN
        chk("bp_second_latency", w, 4);
`else
        chk("bp_second_latency", w, 5);
`endif
        chk_flags("bp_second", 16'hF0F0, 1'b0, 1'b0, 1'b1, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // reset after two RUN edges discards the partial result
        op = 3'b000; a = 16'h1234; b = 16'h1111; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk_flags("midrst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("midrst_no_stale", seen, 0);
        do_op('{3'b000, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0}, "post_rst");

`ifdef ALU_SERIAL_B2B_EN
        op = 3'b000; a = 16'h0101; b = 16'h0202; c_in = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        seen = 0; w = 0;
        for (int cyc = 0; cyc < 40 && seen < 3; cyc++) begin
            if (in_valid && in_ready) w++;
            if (out_valid) begin
                t[seen] = cyc;
                seen++;
                chk("b2b_result", result, 16'h0303);
            end
            @(posedge clk); #1;
            if (w == 3) in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_pulses", seen, 3);
        chk("b2b_gap1", t[1] - t[0], 5);
        chk("b2b_gap2", t[2] - t[1], 5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
